// File: rtl/zero_flag_pkg.sv
// Shared types and elaboration-time helpers for the pipelined zero-detect / NZCV flag unit.
package zero_flag_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [3:0] flags_t;

    // Per-operation sideband that rides alongside the OR tree.
    typedef struct packed {
        logic neg;
        logic carry;
        logic ovf;
        logic set_flags;
    } side_t;

    // Smallest L such that base**L >= value.
    function automatic int unsigned clog_base(input int unsigned value, input int unsigned base);
        int unsigned      levels;
        longint unsigned  span;
        levels = 0;
        span   = 1;
        while (span < 64'(value)) begin
            span   = span * 64'(base);
            levels = levels + 1;
        end
        return levels;
    endfunction

    // Number of nodes feeding tree level 'level' (level 0 is the raw input width).
    function automatic int unsigned node_count(input int unsigned width,
                                               input int unsigned fanin,
                                               input int unsigned level);
        int unsigned n;
        n = width;
        for (int unsigned l = 0; l < level; l++) begin
            n = (n + fanin - 1) / fanin;
        end
        return n;
    endfunction

endpackage

// File: rtl/or_tree_stage.sv
// One registered OR-reduction level of the zero-detect tree, carrying valid and sideband.
module or_tree_stage
    import zero_flag_pkg::*;
#(
    parameter int unsigned IN_W       = 4,
    parameter int unsigned FANIN      = 4,
    parameter bit          INVERT_OUT = 1'b0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              flush,
    input  logic                              in_valid,
    input  logic [IN_W-1:0]                   in_data,
    input  side_t                             in_side,
    output logic                              out_valid,
    output logic [(IN_W+FANIN-1)/FANIN-1:0]   out_data,
    output side_t                             out_side
);

    localparam int unsigned OUT_W = (IN_W + FANIN - 1) / FANIN;
    localparam int unsigned PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] padded_c;
    logic [OUT_W-1:0] node_c;

    // Missing bits of the last group are zero, so they never mask a set bit.
    assign padded_c = PAD_W'(in_data);

    for (genvar n = 0; n < OUT_W; n++) begin : g_node
        assign node_c[n] = |padded_c[n*FANIN +: FANIN];
    end

    // Flush beats stall; data may take whatever is on the input while flushing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_side  <= '0;
        end else if (flush || !stall) begin
            out_valid <= in_valid & ~flush;
            out_data  <= INVERT_OUT ? ~node_c : node_c;
            out_side  <= in_side;
        end
    end

endmodule

// File: rtl/zero_flag_pipe.sv
// Pipelined zero/negative detect with NZCV flag register, for the execute/memory boundary.
module zero_flag_pipe
    import zero_flag_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned FANIN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_carry,
    input  logic             in_ovf,
    input  logic             in_set_flags,
    output logic             out_valid,
    output logic             out_zero,
    output logic             out_neg,
    output flags_t           flags
);

    localparam int unsigned LEVELS = clog_base(WIDTH, FANIN);
    localparam int unsigned LAST   = LEVELS - 1;

    side_t  in_side_c;
    side_t  last_side_c;
    flags_t flags_next_c;

    assign in_side_c = '{neg:       in_data[WIDTH-1],
                         carry:     in_carry,
                         ovf:       in_ovf,
                         set_flags: in_set_flags};

    for (genvar i = 0; i < LEVELS; i++) begin : g_level
        localparam int unsigned IN_W  = node_count(WIDTH, FANIN, i);
        localparam int unsigned OUT_W = node_count(WIDTH, FANIN, i + 1);

        logic [IN_W-1:0]  d;
        logic             v;
        side_t            s;
        logic [OUT_W-1:0] q;
        logic             qv;
        side_t            qs;

        if (i == 0) begin : g_head
            assign d = in_data;
            assign v = in_valid;
            assign s = in_side_c;
        end else begin : g_tail
            assign d = g_level[i-1].q;
            assign v = g_level[i-1].qv;
            assign s = g_level[i-1].qs;
        end

        // Final level stores the NOR so out_zero is a flop output.
        or_tree_stage #(
            .IN_W       (IN_W),
            .FANIN      (FANIN),
            .INVERT_OUT (i == LEVELS - 1)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .stall     (stall),
            .flush     (flush),
            .in_valid  (v),
            .in_data   (d),
            .in_side   (s),
            .out_valid (qv),
            .out_data  (q),
            .out_side  (qs)
        );
    end

    assign out_valid   = g_level[LAST].qv;
    assign out_zero    = g_level[LAST].q[0];
    assign last_side_c = g_level[LAST].qs;
    assign out_neg     = last_side_c.neg;

    // Flags load only when the output entry actually retires this edge.
    always_comb begin
        flags_next_c = flags;
        if (out_valid && last_side_c.set_flags && !stall && !flush) begin
            flags_next_c[FLAG_N] = out_neg;
            flags_next_c[FLAG_Z] = out_zero;
            flags_next_c[FLAG_C] = last_side_c.carry;
            flags_next_c[FLAG_V] = last_side_c.ovf;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else begin
            flags <= flags_next_c;
        end
    end

endmodule

// File: tb/tb_zero_flag_pipe.sv
// Scoreboard bench for zero_flag_pipe: a 64/4 instance and a 37/3 instance driven in turn.
module tb_zero_flag_pipe;
    import zero_flag_pkg::*;

    localparam int unsigned L64 = 3;
    localparam int unsigned L37 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall [2];
    logic        flush [2];
    logic        in_valid [2];
    logic        in_carry [2];
    logic        in_ovf [2];
    logic        in_set [2];
    logic [63:0] in_data64;
    logic [36:0] in_data37;
    logic        o_valid [2];
    logic        o_zero [2];
    logic        o_neg [2];
    flags_t      o_flags [2];

    typedef struct {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic set_flags;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    flags_t exp_flags [2];
    int     n_chk  = 0;
    int     n_fail = 0;

    zero_flag_pipe #(.WIDTH(64), .FANIN(4)) u_dut64 (
        .clk(clk), .reset(reset), .stall(stall[0]), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_data(in_data64), .in_carry(in_carry[0]),
        .in_ovf(in_ovf[0]), .in_set_flags(in_set[0]),
        .out_valid(o_valid[0]), .out_zero(o_zero[0]), .out_neg(o_neg[0]), .flags(o_flags[0])
    );

    zero_flag_pipe #(.WIDTH(37), .FANIN(3)) u_dut37 (
        .clk(clk), .reset(reset), .stall(stall[1]), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_data(in_data37), .in_carry(in_carry[1]),
        .in_ovf(in_ovf[1]), .in_set_flags(in_set[1]),
        .out_valid(o_valid[1]), .out_zero(o_zero[1]), .out_neg(o_neg[1]), .flags(o_flags[1])
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the presented entry with the queue head; retire it only when it advances.
    task automatic mon(input int d);
        exp_t e;
        int   sz;
        if (!reset) begin
            if (d == 0) q0.delete(); else q1.delete();
            exp_flags[d] = '0;
            return;
        end
        chk($sformatf("flags_dut%0d", d), o_flags[d], exp_flags[d]);
        sz = (d == 0) ? q0.size() : q1.size();
        if (o_valid[d] === 1'b1) begin
            if (sz == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid_dut%0d: got out_valid=1 required 0 (no entry in flight) at %0t", d, $time);
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                chk($sformatf("zero_neg_dut%0d", d), {2'b00, o_zero[d], o_neg[d]}, {2'b00, e.zero, e.neg});
                if (!stall[d] && !flush[d]) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    if (e.set_flags) exp_flags[d] = {e.neg, e.zero, e.carry, e.ovf};
                end
            end
        end
        if (flush[d]) begin
            if (d == 0) q0.delete(); else q1.delete();
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    // Drive one cycle of stimulus, record its expected result, advance past the capturing edge.
    task automatic issue(input int d, input logic [63:0] data, input logic v, input logic c,
                         input logic o, input logic s, input logic st, input logic fl);
        exp_t e;
        in_valid[d] = v;
        in_carry[d] = c;
        in_ovf[d]   = o;
        in_set[d]   = s;
        stall[d]    = st;
        flush[d]    = fl;
        if (d == 0) in_data64 = data; else in_data37 = data[36:0];
        if (v && !st && !fl) begin
            e.zero      = (d == 0) ? (data == 64'd0) : (data[36:0] == 37'd0);
            e.neg       = (d == 0) ? data[63] : data[36];
            e.carry     = c;
            e.ovf       = o;
            e.set_flags = s;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bubble(input int d, input int n);
        repeat (n) issue(d, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_op(input int d, input int unsigned w);
        logic [63:0] data;
        logic        st;
        logic        fl;
        case ($urandom_range(0, 3))
            0:       data = 64'd0;
            1:       data = 64'd1 << $urandom_range(0, w - 1);
            default: data = {$urandom, $urandom};
        endcase
        st = ($urandom_range(0, 5) == 0);
        fl = ($urandom_range(0, 11) == 0);
        issue(d, data, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), st, fl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] data;
        flags_t      fb;
        reset     = 1'b0;
        in_data64 = '0;
        in_data37 = '0;
        for (int d = 0; d < 2; d++) begin
            stall[d] = 1'b0; flush[d] = 1'b0; in_valid[d] = 1'b0;
            in_carry[d] = 1'b0; in_ovf[d] = 1'b0; in_set[d] = 1'b0;
            exp_flags[d] = '0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("reset_outputs", {1'b0, o_valid[d], o_zero[d], o_neg[d]}, 4'b0000);
            chk("reset_flags", o_flags[d], 4'b0000);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Zero operand with carry: result after LEVELS edges, flags one edge later.
        issue(0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lat64_e0", {3'b000, o_valid[0]}, 4'b0000);
        bubble(0, 1);
        chk("lat64_e1", {3'b000, o_valid[0]}, 4'b0000);
        bubble(0, 1);
        chk("lat64_e2", {1'b0, o_valid[0], o_zero[0], o_neg[0]}, 4'b0110);
        bubble(0, 1);
        chk("flags_first", o_flags[0], 4'b0110);

        // Walking one: never zero, continuous valid at one op per cycle.
        for (int i = 0; i < 65; i++) begin
            data = (i < 64) ? (64'd1 << i) : 64'd0;
            issue(0, data, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (i >= int'(L64) - 1) chk("throughput64", {3'b000, o_valid[0]}, 4'b0001);
        end
        bubble(0, 4);

        // Negative with overflow, then a non-flag-setting op must not disturb NZCV.
        issue(0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(0, 64'h0000_0000_0000_0055, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bubble(0, 4);
        chk("flags_neg_ovf", o_flags[0], 4'b1001);

        // Three in flight, stalled three cycles.
        for (int i = 0; i < 3; i++)
            issue(0, {$urandom, $urandom} | 64'd1, 1'b1, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue(0, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            chk("stall_hold_valid", {3'b000, o_valid[0]}, 4'b0001);
        end
        bubble(0, 4);

        // Flush with stall while a flag-setting entry sits at the output.
        issue(0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(0, 64'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(0, 64'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("flush_pre_valid", {3'b000, o_valid[0]}, 4'b0001);
        fb = exp_flags[0];
        issue(0, 64'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("flush_valid", {3'b000, o_valid[0]}, 4'b0000);
        chk("flush_flags", o_flags[0], fb);
        for (int i = 0; i < 3; i++) begin
            bubble(0, 1);
            chk("flush_empty", {3'b000, o_valid[0]}, 4'b0000);
        end

        for (int i = 0; i < 150; i++) rand_op(0, 64);
        bubble(0, 5);

        // 37-bit / fanin 3 instance: four-level latency, MSB alone must not read as zero.
        issue(1, 64'd1 << 36, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lat37_e1", {3'b000, o_valid[1]}, 4'b0000);
        bubble(1, 1);
        chk("lat37_e2", {3'b000, o_valid[1]}, 4'b0000);
        bubble(1, 1);
        chk("lat37_msb", {1'b0, o_valid[1], o_zero[1], o_neg[1]}, 4'b0101);
        bubble(1, 1);
        chk("lat37_zero", {1'b0, o_valid[1], o_zero[1], o_neg[1]}, 4'b0110);
        chk("flags37", o_flags[1], 4'b1000);
        bubble(1, L37);

        for (int i = 0; i < 120; i++) rand_op(1, 37);
        bubble(1, 5);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) issue(1, 64'd1 << 36, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_valid", {3'b000, o_valid[1]}, 4'b0001);
        chk("pre_reset_flags", o_flags[1], 4'b1010);
        in_valid[1] = 1'b0;
        reset = 1'b0;
        #2;
        chk("async_reset_valid", {1'b0, o_valid[1], o_zero[1], o_neg[1]}, 4'b0000);
        chk("async_reset_flags", o_flags[1], 4'b0000);
        chk("async_reset_flags64", o_flags[0], 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(1, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        bubble(1, 5);
        chk("post_reset_flags", o_flags[1], 4'b0111);

        n_chk++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d entries never emerged required 0/0", q0.size(), q1.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
